// File: rtl/ex_stage_if.sv
// Decode-to-execute instruction bus: valid/allowin handshake plus the decoded payload.
// Decode drives the master side; the execute stage is the slave.
interface ex_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
);
  logic                  ds_to_es_valid;
  logic                  es_allowin;
  logic [31:0]           ds_pc;
  logic [3:0]            ds_alu_op;
  logic [DATA_WIDTH-1:0] ds_rs_val;
  logic [DATA_WIDTH-1:0] ds_rt_val;
  logic [REG_AW-1:0]     ds_rs;
  logic [REG_AW-1:0]     ds_rt;
  logic [DATA_WIDTH-1:0] ds_imm;
  logic [4:0]            ds_sa;
  logic                  ds_src1_is_sa;
  logic                  ds_src2_is_imm;
  logic [REG_AW-1:0]     ds_dest;
  logic                  ds_gr_we;
  logic                  ds_ov_en;

  modport master (
    output ds_to_es_valid, ds_pc, ds_alu_op, ds_rs_val, ds_rt_val, ds_rs, ds_rt,
           ds_imm, ds_sa, ds_src1_is_sa, ds_src2_is_imm, ds_dest, ds_gr_we, ds_ov_en,
    input  es_allowin
  );

  modport slave (
    input  ds_to_es_valid, ds_pc, ds_alu_op, ds_rs_val, ds_rt_val, ds_rs, ds_rt,
           ds_imm, ds_sa, ds_src1_is_sa, ds_src2_is_imm, ds_dest, ds_gr_we, ds_ov_en,
    output es_allowin
  );
endinterface

// File: rtl/ex_stage.sv
// Execute-stage pipeline register of the 5-stage MIPS core: latches one decoded
// instruction, resolves MEM/WB bypasses, drives the external ALU and hands its result to MEM.
module ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  ex_stage_if.slave             ds,
  input  logic                  ms_fwd_we,
  input  logic [REG_AW-1:0]     ms_fwd_dest,
  input  logic [DATA_WIDTH-1:0] ms_fwd_val,
  input  logic                  ws_fwd_we,
  input  logic [REG_AW-1:0]     ws_fwd_dest,
  input  logic [DATA_WIDTH-1:0] ws_fwd_val,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow,
  input  logic                  ms_allowin,
  output logic                  es_to_ms_valid,
  output logic [31:0]           es_pc,
  output logic [DATA_WIDTH-1:0] es_result,
  output logic [REG_AW-1:0]     es_dest,
  output logic                  es_gr_we,
  output logic                  es_exc_ov,
  output logic                  es_fwd_we,
  output logic [REG_AW-1:0]     es_fwd_dest,
  output logic [DATA_WIDTH-1:0] es_fwd_val
);

  localparam logic ES_READY_GO = 1'b1;

  logic                  vld_p1;
  logic [31:0]           pc_p1;
  logic [3:0]            op_p1;
  logic [DATA_WIDTH-1:0] rs_val_p1;
  logic [DATA_WIDTH-1:0] rt_val_p1;
  logic [REG_AW-1:0]     rs_p1;
  logic [REG_AW-1:0]     rt_p1;
  logic [DATA_WIDTH-1:0] imm_p1;
  logic [4:0]            sa_p1;
  logic                  src1_is_sa_p1;
  logic                  src2_is_imm_p1;
  logic [REG_AW-1:0]     dest_p1;
  logic                  gr_we_p1;
  logic                  ov_en_p1;

  logic                  allowin;
  logic                  accept;
  logic [DATA_WIDTH-1:0] fwd_rs;
  logic [DATA_WIDTH-1:0] fwd_rt;

  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [REG_AW-1:0]     reg_num,
    input logic [DATA_WIDTH-1:0] reg_val,
    input logic                  m_we,
    input logic [REG_AW-1:0]     m_dest,
    input logic [DATA_WIDTH-1:0] m_val,
    input logic                  w_we,
    input logic [REG_AW-1:0]     w_dest,
    input logic [DATA_WIDTH-1:0] w_val
  );
    logic [DATA_WIDTH-1:0] sel;
    sel = reg_val;
    if (reg_num != '0) begin
      if (m_we && m_dest == reg_num)      sel = m_val;
      else if (w_we && w_dest == reg_num) sel = w_val;
    end
    return sel;
  endfunction

  assign allowin       = !vld_p1 || (ES_READY_GO && ms_allowin);
  assign ds.es_allowin = allowin;
  assign accept        = ds.ds_to_es_valid && allowin && !flush;

  // ---- stage p0 -> p1: decode handshake and payload capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld_p1 <= 1'b0;
    else if (flush)   vld_p1 <= 1'b0;
    else if (allowin) vld_p1 <= ds.ds_to_es_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p1          <= '0;
      op_p1          <= '0;
      rs_val_p1      <= '0;
      rt_val_p1      <= '0;
      rs_p1          <= '0;
      rt_p1          <= '0;
      imm_p1         <= '0;
      sa_p1          <= '0;
      src1_is_sa_p1  <= 1'b0;
      src2_is_imm_p1 <= 1'b0;
      dest_p1        <= '0;
      gr_we_p1       <= 1'b0;
      ov_en_p1       <= 1'b0;
    end else if (accept) begin
      pc_p1          <= ds.ds_pc;
      op_p1          <= ds.ds_alu_op;
      rs_val_p1      <= ds.ds_rs_val;
      rt_val_p1      <= ds.ds_rt_val;
      rs_p1          <= ds.ds_rs;
      rt_p1          <= ds.ds_rt;
      imm_p1         <= ds.ds_imm;
      sa_p1          <= ds.ds_sa;
      src1_is_sa_p1  <= ds.ds_src1_is_sa;
      src2_is_imm_p1 <= ds.ds_src2_is_imm;
      dest_p1        <= ds.ds_dest;
      gr_we_p1       <= ds.ds_gr_we;
      ov_en_p1       <= ds.ds_ov_en;
    end
  end

  // ---- stage p1: operand resolution and ALU interface (combinational) ----
  // Bypasses are re-evaluated every cycle so a stalled instruction sees late producers.
  assign fwd_rs = fwd_sel(rs_p1, rs_val_p1, ms_fwd_we, ms_fwd_dest, ms_fwd_val,
                          ws_fwd_we, ws_fwd_dest, ws_fwd_val);
  assign fwd_rt = fwd_sel(rt_p1, rt_val_p1, ms_fwd_we, ms_fwd_dest, ms_fwd_val,
                          ws_fwd_we, ws_fwd_dest, ws_fwd_val);

  assign alu_a  = src1_is_sa_p1 ? {{(DATA_WIDTH-5){1'b0}}, sa_p1} : fwd_rs;
  assign alu_b  = src2_is_imm_p1 ? imm_p1 : fwd_rt;
  assign alu_op = op_p1;

  // Result is masked while empty so an idle or resetting stage presents zero.
  assign es_result      = vld_p1 ? alu_result : '0;
  assign es_exc_ov      = vld_p1 && ov_en_p1 && alu_overflow;
  assign es_gr_we       = gr_we_p1 && !es_exc_ov;
  assign es_to_ms_valid = vld_p1 && ES_READY_GO && !flush;
  assign es_pc          = pc_p1;
  assign es_dest        = dest_p1;
  assign es_fwd_we      = vld_p1 && es_gr_we;
  assign es_fwd_dest    = dest_p1;
  assign es_fwd_val     = es_result;

endmodule
